// File: rtl/kij_seq_pkg.sv
// Shared definitions for the kij sequencer: FSM states, inst_w encodings and defaults.
package kij_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLR,
        S_WREQ,
        S_LDW,
        S_GAP,
        S_LDX,
        S_DRAIN,
        S_RELU,
        S_RD,
        S_FIN
    } state_t;

    localparam logic [1:0] INST_IDLE = 2'b00;
    localparam logic [1:0] INST_LDW  = 2'b01;
    localparam logic [1:0] INST_LDX  = 2'b10;

    localparam int unsigned W_BASE = 1024;
    localparam int unsigned CNT_W  = 16;

endpackage

// File: rtl/seq_cnt.sv
// Loadable down-counter shared by all sequencer states; the up tap counts cycles
// since the last load and drives address generation.
module seq_cnt #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero,
    output logic [CNT_W-1:0] up
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            up  <= '0;
        end else if (load) begin
            cnt <= load_val;
            up  <= '0;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
            up  <= up + 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/kij_sequencer.sv
// Walks the kij loop for the convolution core: clear, weight handshake with the host,
// weight/activation streaming from X_MEM, drain, then ReLU wait and readout.
module kij_sequencer
    import kij_seq_pkg::*;
#(
    parameter int unsigned row          = 8,
    parameter int unsigned col          = 8,
    parameter int unsigned len_nij      = 36,
    parameter int unsigned len_kij      = 9,
    parameter int unsigned addr_w       = 11,
    parameter int unsigned w_base       = W_BASE,
    parameter int unsigned clr_cycles   = 10,
    parameter int unsigned drain_cycles = 30,
    parameter int unsigned relu_cycles  = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              act_2b_mode,
    input  logic              wgt_ready,
    output logic              host_grant,
    output logic              busy,
    output logic              done,
    output logic              core_clr,
    output logic              CEN_xmem,
    output logic              WEN_xmem,
    output logic [addr_w-1:0] A_xmem,
    output logic [1:0]        inst_w,
    output logic [3:0]        kij,
    output logic              readout_start
);

    if (row < 1 || col < 1 || len_nij < 1 || len_kij < 1 || len_kij > 16 ||
        clr_cycles < 1 || drain_cycles < 1 || relu_cycles < 1 ||
        w_base + 2 * col > (32'd1 << addr_w) || len_nij > (32'd1 << addr_w)) begin : g_cfg_err
        $error("kij_sequencer: parameter set does not fit the address/counter widths");
    end

    localparam logic [CNT_W-1:0]  CLR_LD   = CNT_W'(clr_cycles - 1);
    localparam logic [CNT_W-1:0]  LDX_LD   = CNT_W'(len_nij - 1);
    localparam logic [CNT_W-1:0]  DRAIN_LD = CNT_W'(drain_cycles - 1);
    localparam logic [CNT_W-1:0]  RELU_LD  = CNT_W'(relu_cycles - 1);
    localparam logic [CNT_W-1:0]  NW1_LD   = CNT_W'(col - 1);
    localparam logic [CNT_W-1:0]  NW2_LD   = CNT_W'(2 * col - 1);
    localparam logic [3:0]        LAST_KIJ = 4'(len_kij - 1);
    localparam logic [addr_w-1:0] W_BASE_A = addr_w'(w_base);

    state_t           state, next_state;
    logic             nw_sel;
    logic             cnt_load, cnt_zero;
    logic [CNT_W-1:0] cnt_val, cnt_up;
    logic             kij_clr, kij_inc;

    seq_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero),
        .up       (cnt_up)
    );

    // Every transition reloads the shared counter with the next state's length minus one.
    always_comb begin
        next_state = state;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        kij_clr    = 1'b0;
        kij_inc    = 1'b0;
        unique case (state)
            S_IDLE: if (start) begin
                next_state = S_CLR;
                cnt_load   = 1'b1;
                cnt_val    = CLR_LD;
                kij_clr    = 1'b1;
            end
            S_CLR: if (cnt_zero) begin
                next_state = S_WREQ;
                cnt_load   = 1'b1;
            end
            S_WREQ: if (cnt_zero && wgt_ready) begin
                next_state = S_LDW;
                cnt_load   = 1'b1;
                cnt_val    = nw_sel ? NW2_LD : NW1_LD;
            end
            S_LDW: if (cnt_zero) begin
                next_state = S_GAP;
                cnt_load   = 1'b1;
            end
            S_GAP: if (cnt_zero) begin
                next_state = S_LDX;
                cnt_load   = 1'b1;
                cnt_val    = LDX_LD;
            end
            S_LDX: if (cnt_zero) begin
                next_state = S_DRAIN;
                cnt_load   = 1'b1;
                cnt_val    = DRAIN_LD;
            end
            S_DRAIN: if (cnt_zero) begin
                cnt_load = 1'b1;
                if (kij == LAST_KIJ) begin
                    next_state = S_RELU;
                    cnt_val    = RELU_LD;
                end else begin
                    next_state = S_CLR;
                    cnt_val    = CLR_LD;
                    kij_inc    = 1'b1;
                end
            end
            S_RELU: if (cnt_zero) begin
                next_state = S_RD;
                cnt_load   = 1'b1;
            end
            S_RD: if (cnt_zero) begin
                next_state = S_FIN;
                cnt_load   = 1'b1;
            end
            S_FIN: if (cnt_zero) begin
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            nw_sel <= 1'b0;
            kij    <= '0;
        end else begin
            state <= next_state;
            if (kij_clr) begin
                nw_sel <= act_2b_mode;
                kij    <= '0;
            end else if (kij_inc) begin
                kij <= kij + 1'b1;
            end
        end
    end

    // Outputs are registered decodes of the current state, so they trail it by one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            host_grant    <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            core_clr      <= 1'b0;
            CEN_xmem      <= 1'b1;
            A_xmem        <= '0;
            inst_w        <= INST_IDLE;
            readout_start <= 1'b0;
        end else begin
            host_grant    <= (state == S_IDLE) || (state == S_WREQ);
            busy          <= (state != S_IDLE);
            done          <= (state == S_FIN);
            core_clr      <= (state == S_CLR);
            readout_start <= (state == S_RD);
            CEN_xmem      <= !((state == S_LDW) || (state == S_LDX));
            unique case (state)
                S_LDW: begin
                    inst_w <= INST_LDW;
                    A_xmem <= W_BASE_A + addr_w'(cnt_up);
                end
                S_LDX: begin
                    inst_w <= INST_LDX;
                    A_xmem <= addr_w'(cnt_up);
                end
                default: begin
                    inst_w <= INST_IDLE;
                    A_xmem <= '0;
                end
            endcase
        end
    end

    assign WEN_xmem = 1'b1;

endmodule

// File: tb/tb_kij_sequencer.sv
// Scoreboard bench for kij_sequencer: a job-level model queues the expected X_MEM
// reads and readout/done pulses; a monitor pops and compares whatever the DUT emits.
module tb_kij_sequencer;
    import kij_seq_pkg::*;

    localparam int unsigned COL     = 8;
    localparam int unsigned LEN_NIJ = 36;
    localparam int unsigned LEN_KIJ = 9;
    localparam int unsigned ADDR_W  = 11;
    localparam int unsigned WB      = 1024;
    localparam int unsigned CLR_N   = 10;
    localparam int unsigned DRAIN_N = 30;
    localparam int unsigned RELU_N  = 20;
    localparam int          EV_W = 0, EV_X = 1, EV_RO = 2, EV_DONE = 3;
    localparam int          JOB_BUDGET = 4000;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              act_2b_mode = 1'b0;
    logic              wgt_ready = 1'b0;
    logic              host_grant, busy, done, core_clr, CEN_xmem, WEN_xmem, readout_start;
    logic [ADDR_W-1:0] A_xmem;
    logic [1:0]        inst_w;
    logic [3:0]        kij;

    kij_sequencer #(
        .row(8), .col(COL), .len_nij(LEN_NIJ), .len_kij(LEN_KIJ), .addr_w(ADDR_W),
        .w_base(WB), .clr_cycles(CLR_N), .drain_cycles(DRAIN_N), .relu_cycles(RELU_N)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .act_2b_mode(act_2b_mode),
        .wgt_ready(wgt_ready), .host_grant(host_grant), .busy(busy), .done(done),
        .core_clr(core_clr), .CEN_xmem(CEN_xmem), .WEN_xmem(WEN_xmem), .A_xmem(A_xmem),
        .inst_w(inst_w), .kij(kij), .readout_start(readout_start)
    );

    always #5 clk = ~clk;

    // gap = cycles since the previous event; -1 means "timed from the wgt_ready pulse".
    typedef struct {
        int kind;
        int addr;
        int kij;
        int gap;
    } ev_t;

    ev_t         exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int unsigned cyc = 0;
    int unsigned last_ev_cyc = 0;
    int unsigned wr_edge = 0;
    int unsigned done_cnt = 0;
    int unsigned clr_run = 0;
    int unsigned jobs_expected = 0;
    int unsigned stray_req = 0;
    int unsigned stray_done = 0;
    int          host_delay = 2;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endfunction

    // Reference model: one job is len_kij passes of nw weight reads then len_nij activation reads.
    function automatic void push_job(input bit mode);
        int nw = mode ? int'(2 * COL) : int'(COL);
        for (int k = 0; k < int'(LEN_KIJ); k++) begin
            for (int t = 0; t < nw; t++)
                exp_q.push_back('{EV_W, int'(WB) + t, k, (t == 0) ? -1 : 1});
            for (int t = 0; t < int'(LEN_NIJ); t++)
                exp_q.push_back('{EV_X, t, k, (t == 0) ? 2 : 1});
        end
        exp_q.push_back('{EV_RO, 0, int'(LEN_KIJ) - 1, int'(DRAIN_N + RELU_N) + 1});
        exp_q.push_back('{EV_DONE, 0, int'(LEN_KIJ) - 1, 1});
    endfunction

    ev_t e;
    int  kind;

    always @(negedge clk) begin
        if (reset) begin
            if (host_grant)
                check("grant_bus_idle", int'({CEN_xmem, inst_w}), 4);
            if (core_clr) begin
                clr_run++;
            end else if (clr_run != 0) begin
                check("core_clr_len", int'(clr_run), int'(CLR_N));
                clr_run = 0;
            end
            if (!CEN_xmem || readout_start || done) begin
                if (done)               kind = EV_DONE;
                else if (readout_start) kind = EV_RO;
                else if (inst_w == INST_LDW) kind = EV_W;
                else if (inst_w == INST_LDX) kind = EV_X;
                else                    kind = -1;
                if (done) done_cnt++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_event: got kind %0d addr %0d kij %0d, expected none (cycle %0d)",
                             kind, A_xmem, kij, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("ev_kind", kind, e.kind);
                    check("ev_kij", int'(kij), e.kij);
                    if (e.kind == EV_W || e.kind == EV_X) begin
                        check("ev_addr", int'(A_xmem), e.addr);
                        check("read_no_grant", int'(host_grant), 0);
                    end
                    if (e.gap >= 0) check("ev_gap", int'(cyc - last_ev_cyc), e.gap);
                    else            check("wgt_to_read", int'(cyc), int'(wr_edge) + 1);
                end
                last_ev_cyc = cyc;
            end
        end
    end

    // Host model: answers each WREQ after host_delay cycles; also injects stray pulses during LDX.
    initial begin
        forever begin
            @(negedge clk);
            if (stray_req != stray_done && inst_w == INST_LDX) begin
                wgt_ready = 1'b1;
                @(negedge clk);
                wgt_ready = 1'b0;
                stray_done++;
            end else if (reset && busy && host_grant) begin
                int d = (host_delay < 0) ? int'($urandom_range(0, 4)) : host_delay;
                repeat (d) @(negedge clk);
                if (reset && busy && host_grant) begin
                    wgt_ready = 1'b1;
                    wr_edge   = cyc + 1;
                    @(negedge clk);
                    wgt_ready = 1'b0;
                    for (int i = 0; i < 8 && host_grant; i++) @(negedge clk);
                end
            end
        end
    end

    task automatic start_job(input bit mode);
        @(negedge clk); #1;
        act_2b_mode = mode;
        start       = 1'b1;
        push_job(mode);
        @(negedge clk); #1;
        start = 1'b0;
        check("start_lag", int'({busy, core_clr}), 0);
        @(negedge clk); #1;
        check("start_busy_clr", int'({busy, core_clr}), 3);
    endtask

    task automatic run_job(input bit mode, input bit toggle, input bit poke);
        int unsigned d0 = done_cnt;
        bit saw = 1'b0, poked = 1'b0, finished = 1'b0;
        start_job(mode);
        jobs_expected++;
        for (int i = 0; i < JOB_BUDGET && !finished; i++) begin
            @(negedge clk); #1;
            if (toggle) act_2b_mode = 1'($urandom_range(0, 1));
            if (poke && !poked) begin
                if (kij == 4'd5 && inst_w == INST_LDX) begin
                    saw = 1'b1;
                end else if (saw && busy && inst_w == INST_IDLE) begin
                    start = 1'b1;
                    @(negedge clk); #1;
                    start = 1'b0;
                    poked = 1'b1;
                end
            end
            if (done_cnt != d0 && exp_q.size() == 0) finished = 1'b1;
        end
        if (!finished) begin
            n_cmp++;
            n_err++;
            $display("FAIL job_timeout: got %0d events pending, expected 0 within %0d cycles",
                     exp_q.size(), JOB_BUDGET);
        end
    endtask

    initial begin
        bit found;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_host_grant", int'(host_grant), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_core_clr", int'(core_clr), 0);
        check("rst_cen", int'(CEN_xmem), 1);
        check("rst_wen", int'(WEN_xmem), 1);
        check("rst_addr", int'(A_xmem), 0);
        check("rst_inst_w", int'(inst_w), 0);
        check("rst_kij", int'(kij), 0);
        check("rst_readout", int'(readout_start), 0);
        reset = 1'b1;

        // Abandon a job mid-LDX at kij=3, t=20.
        host_delay = 1;
        start_job(1'b0);
        found = 1'b0;
        for (int i = 0; i < JOB_BUDGET && !found; i++) begin
            @(negedge clk); #1;
            if (kij == 4'd3 && inst_w == INST_LDX && A_xmem == 20) found = 1'b1;
        end
        check("reach_kij3_t20", int'(found), 1);
        #1 reset = 1'b0;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_cen", int'(CEN_xmem), 1);
        check("mid_rst_inst_w", int'(inst_w), 0);
        check("mid_rst_kij", int'(kij), 0);
        check("mid_rst_grant", int'(host_grant), 1);
        exp_q.delete();
        clr_run = 0;
        @(negedge clk); #1;
        reset = 1'b1;

        host_delay = 2;
        run_job(1'b0, 1'b0, 1'b0);

        host_delay = 1;
        run_job(1'b1, 1'b1, 1'b0);

        host_delay = 100;
        stray_req++;
        run_job(1'b0, 1'b0, 1'b0);
        check("stray_pulse_sent", int'(stray_done), int'(stray_req));

        host_delay = 0;
        run_job(1'b0, 1'b0, 1'b1);

        host_delay = 3;
        run_job(1'b0, 1'b0, 1'b0);
        run_job(1'b1, 1'b0, 1'b0);

        host_delay = -1;
        for (int j = 0; j < 3; j++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_job(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        repeat (60) @(negedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);
        check("done_total", int'(done_cnt), int'(jobs_expected));
        check("end_busy", int'(busy), 0);
        check("end_grant", int'(host_grant), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
